mem_port_arbiter: RTL and testbench

//  Shares one single-port 64-bit memory between the instruction-fetch port (I) and the load/store data port (D).

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64-bit memory between fetch (I) and load/store (D). D wins unless fetch has waited MAX_D_STREAK grants.
// Latency: load ack 2+MEM_LATENCY, store ack 2, misaligned fetch ack 1. Requesters hold req until ack; requests are sampled only in IDLE.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIReq,
  input  logic [63:0] iIAddress,
  output logic [31:0] oIReadData,
  output logic        oIAck,
  output logic        oIFault,
  input  logic        iDReq,
  input  logic        iDWrite,
  input  logic [63:0] iDAddress,
  input  logic [63:0] iDWriteData,
  input  logic [7:0]  iDByteEnable,
  output logic [63:0] oDReadData,
  output logic        oDAck,
  output logic        oMemEnable,
  output logic        oMemWrite,
  output logic [63:0] oMemAddress,
  output logic [63:0] oMemWriteData,
  output logic [7:0]  oMemByteEnable,
  input  logic [63:0] iMemReadData,
  output logic        oBusyD
);
  localparam int         LAT_INT    = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
  localparam logic [3:0] LAT        = 4'(LAT_INT);
  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

  typedef struct packed {
    logic        ownerD;
    logic        write;
    logic        fault;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } accessT;

  stateT       state, nextState;
  accessT      acc;
  logic [3:0]  streak;
  logic [3:0]  latCount;
  logic [63:0] readReg;
  logic        grantD, grantI, misaligned;

  assign misaligned = iIAddress[1:0] != 2'b00;
  assign grantD     = iDReq && (!iIReq || streak != MAX_STREAK);
  assign grantI     = iIReq && !grantD;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    oMemEnable = 1'b0;
    oMemWrite  = 1'b0;
    oIAck      = 1'b0;
    oIFault    = 1'b0;
    oIReadData = 32'h0;
    oDAck      = 1'b0;
    oDReadData = 64'h0;
    oBusyD     = acc.ownerD && (state != IDLE);
    case (state)
      IDLE: begin
        // A misaligned fetch is answered without touching memory.
        if (grantD || (grantI && !misaligned)) nextState = ISSUE;
        else if (grantI)                       nextState = DONE;
      end
      ISSUE: begin
        oMemEnable = 1'b1;
        oMemWrite  = acc.write;
        nextState  = acc.write ? DONE : WAIT;
      end
      WAIT: begin
        if (latCount == LAT) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
        if (acc.ownerD) begin
          oDAck      = 1'b1;
          oDReadData = acc.write ? 64'h0 : readReg;
        end else begin
          oIAck      = 1'b1;
          oIFault    = acc.fault;
          oIReadData = acc.fault ? 32'h0 : (acc.addr[2] ? readReg[63:32] : readReg[31:0]);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      acc      <= '0;
      streak   <= 4'd0;
      latCount <= 4'd0;
      readReg  <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD) begin
            acc <= '{ownerD: 1'b1, write: iDWrite, fault: 1'b0,
                     addr: iDAddress & ~64'h7,
                     wdata: iDWrite ? iDWriteData : 64'h0,
                     be: iDWrite ? iDByteEnable : 8'hFF};
            // Streak only grows while fetch is actually being held off.
            if (!iIReq)                    streak <= 4'd0;
            else if (streak != MAX_STREAK) streak <= streak + 4'd1;
          end else if (grantI) begin
            acc    <= '{ownerD: 1'b0, write: 1'b0, fault: misaligned,
                        addr: iIAddress, wdata: 64'h0, be: 8'hFF};
            streak <= 4'd0;
          end
        end
        ISSUE: latCount <= 4'd1;
        WAIT: begin
          latCount <= latCount + 4'd1;
          if (latCount == LAT) readReg <= iMemReadData;
        end
        default: ;
      endcase
    end
  end

  assign oMemAddress    = acc.addr;
  assign oMemWriteData  = acc.wdata;
  assign oMemByteEnable = acc.be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances (latency 1,3,4,15; streak limit 2) with latency-exact memory responders.
module tb_mem_port_arbiter;
  localparam int NI = 4;

  function automatic int latOf(int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 15;
    endcase
  endfunction

  function automatic logic [63:0] initWord(int i);
    if (i == 32) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {32'h5A00_0000 | 32'(i), 32'hC3C3_0000 ^ (32'(i) * 32'h0001_0203)};
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iIReq [NI];
  logic [63:0] iIAddress [NI];
  logic [31:0] oIReadData [NI];
  logic        oIAck [NI];
  logic        oIFault [NI];
  logic        iDReq [NI];
  logic        iDWrite [NI];
  logic [63:0] iDAddress [NI];
  logic [63:0] iDWriteData [NI];
  logic [7:0]  iDByteEnable [NI];
  logic [63:0] oDReadData [NI];
  logic        oDAck [NI];
  logic        oMemEnable [NI];
  logic        oMemWrite [NI];
  logic [63:0] oMemAddress [NI];
  logic [63:0] oMemWriteData [NI];
  logic [7:0]  oMemByteEnable [NI];
  logic [63:0] iMemReadData [NI];
  logic        oBusyD [NI];

  for (genvar g = 0; g < NI; g++) begin : gDut
    mem_port_arbiter #(
      .MEM_LATENCY (g == 0 ? 1 : (g == 1 ? 3 : (g == 2 ? 4 : 15))),
      .MAX_D_STREAK(2)
    ) dut (
      .iCLK(clk), .iRST(rst),
      .iIReq(iIReq[g]), .iIAddress(iIAddress[g]), .oIReadData(oIReadData[g]),
      .oIAck(oIAck[g]), .oIFault(oIFault[g]),
      .iDReq(iDReq[g]), .iDWrite(iDWrite[g]), .iDAddress(iDAddress[g]),
      .iDWriteData(iDWriteData[g]), .iDByteEnable(iDByteEnable[g]),
      .oDReadData(oDReadData[g]), .oDAck(oDAck[g]),
      .oMemEnable(oMemEnable[g]), .oMemWrite(oMemWrite[g]), .oMemAddress(oMemAddress[g]),
      .oMemWriteData(oMemWriteData[g]), .oMemByteEnable(oMemByteEnable[g]),
      .iMemReadData(iMemReadData[g]), .oBusyD(oBusyD[g])
    );
  end

  // Memory: read data is presented only in the cycle exactly L cycles after the strobe.
  logic [63:0] memArr [NI][64];
  logic        pv [NI][15];
  logic [5:0]  pa [NI][15];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NI; g++) begin
        for (int i = 0; i < 64; i++) memArr[g][i] <= initWord(i);
        for (int s = 0; s < 15; s++) begin
          pv[g][s] <= 1'b0;
          pa[g][s] <= 6'd0;
        end
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (oMemEnable[g] && oMemWrite[g])
          for (int b = 0; b < 8; b++)
            if (oMemByteEnable[g][b])
              memArr[g][oMemAddress[g][8:3]][b*8 +: 8] <= oMemWriteData[g][b*8 +: 8];
        pv[g][0] <= oMemEnable[g] && !oMemWrite[g];
        pa[g][0] <= oMemAddress[g][8:3];
        for (int s = 1; s < 15; s++) begin
          pv[g][s] <= pv[g][s-1];
          pa[g][s] <= pa[g][s-1];
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      iMemReadData[g] = 64'hDEAD_BEEF_DEAD_BEEF;
      if (pv[g][latOf(g)-1]) iMemReadData[g] = memArr[g][pa[g][latOf(g)-1]];
    end
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic anyOut(int g);
    return oIAck[g] | oIFault[g] | (|oIReadData[g]) | oDAck[g] | (|oDReadData[g]) |
           oMemEnable[g] | oMemWrite[g] | (|oMemAddress[g]) | (|oMemWriteData[g]) |
           (|oMemByteEnable[g]) | oBusyD[g];
  endfunction

  typedef struct {
    logic        isI;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          expCyc;
    logic [63:0] expData;
    logic        expFault;
    int          expEn;
    logic [63:0] expMemAddr;
    logic [7:0]  expBe;
    string       name;
  } vecT;

  // Request in the IDLE cycle (cycle 0), then follow the transaction until its ack.
  task automatic runOne(input int g, input vecT v);
    int          ackCyc = -1;
    int          enCnt  = 0;
    logic [63:0] gotData = 64'h0, gotMA = 64'h0;
    logic [7:0]  gotBe = 8'h0;
    logic        gotFault = 1'b0, gotWr = 1'b0;
    logic [1:0]  gotOwner = 2'b00;
    @(negedge clk);
    if (v.isI) begin
      iIReq[g] = 1'b1; iIAddress[g] = v.addr;
    end else begin
      iDReq[g] = 1'b1; iDWrite[g] = v.wr; iDAddress[g] = v.addr;
      iDWriteData[g] = v.wdata; iDByteEnable[g] = v.be;
    end
    for (int c = 1; c <= 40 && ackCyc < 0; c++) begin
      @(negedge clk);
      if (oMemEnable[g]) begin
        enCnt++; gotMA = oMemAddress[g]; gotBe = oMemByteEnable[g]; gotWr = oMemWrite[g];
      end
      if (oIAck[g] || oDAck[g]) begin
        ackCyc   = c;
        gotOwner = {oIAck[g], oDAck[g]};
        gotFault = oIFault[g];
        gotData  = v.isI ? {32'h0, oIReadData[g]} : oDReadData[g];
        iIReq[g] = 1'b0;
        iDReq[g] = 1'b0;
      end
    end
    check($sformatf("%s.cycle", v.name), 64'(ackCyc), 64'(v.expCyc));
    check($sformatf("%s.owner", v.name), 64'(gotOwner), 64'({v.isI, !v.isI}));
    check($sformatf("%s.fault", v.name), 64'(gotFault), 64'(v.expFault));
    check($sformatf("%s.strobes", v.name), 64'(enCnt), 64'(v.expEn));
    if (!v.wr) check($sformatf("%s.data", v.name), gotData, v.expData);
    if (v.expEn > 0) begin
      check($sformatf("%s.memaddr", v.name), gotMA, v.expMemAddr);
      check($sformatf("%s.lanes", v.name), 64'(gotBe), 64'(v.expBe));
      check($sformatf("%s.memwrite", v.name), 64'(gotWr), 64'(v.wr));
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vecT         tbl [8];
  logic [63:0] w4, merged, refMem [64];

  initial begin
    w4     = initWord(4);
    merged = {w4[63:8], 8'h11};
    tbl[0] = '{1'b1, 1'b0, 64'h104, 64'h0, 8'h00, 3, 64'hAAAA_BBBB, 1'b0, 1, 64'h104, 8'hFF, "fetch_hi"};
    tbl[1] = '{1'b1, 1'b0, 64'h100, 64'h0, 8'h00, 3, 64'hCCCC_DDDD, 1'b0, 1, 64'h100, 8'hFF, "fetch_lo"};
    tbl[2] = '{1'b1, 1'b0, 64'h102, 64'h0, 8'h00, 1, 64'h0, 1'b1, 0, 64'h0, 8'h00, "fetch_misaligned"};
    tbl[3] = '{1'b0, 1'b1, 64'h20, 64'h11, 8'h01, 2, 64'h0, 1'b0, 1, 64'h20, 8'h01, "store_byte"};
    tbl[4] = '{1'b0, 1'b0, 64'h20, 64'h0, 8'h00, 3, merged, 1'b0, 1, 64'h20, 8'hFF, "load_after_store"};
    tbl[5] = '{1'b0, 1'b0, 64'h27, 64'h0, 8'h00, 3, merged, 1'b0, 1, 64'h20, 8'hFF, "load_low_bits"};
    tbl[6] = '{1'b0, 1'b1, 64'h38, 64'h0123_4567_89AB_CDEF, 8'hFF, 2, 64'h0, 1'b0, 1, 64'h38, 8'hFF, "store_full"};
    tbl[7] = '{1'b1, 1'b0, 64'h3C, 64'h0, 8'h00, 3, 64'h0123_4567, 1'b0, 1, 64'h3C, 8'hFF, "fetch_stored"};

    for (int g = 0; g < NI; g++) begin
      iIReq[g] = 1'b0; iIAddress[g] = 64'h0; iDReq[g] = 1'b0; iDWrite[g] = 1'b0;
      iDAddress[g] = 64'h0; iDWriteData[g] = 64'h0; iDByteEnable[g] = 8'h0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) check($sformatf("reset_outputs[%0d]", g), 64'(anyOut(g)), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) check($sformatf("idle_outputs[%0d]", g), 64'(anyOut(g)), 64'h0);

    // Reset while a latency-3 fetch sits in WAIT: no ack may follow.
    begin
      int stray = 0;
      vecT rv = '{1'b1, 1'b0, 64'h104, 64'h0, 8'h00, 5, 64'hAAAA_BBBB, 1'b0, 1, 64'h104, 8'hFF, "post_reset_fetch"};
      @(negedge clk);
      iIReq[1] = 1'b1; iIAddress[1] = 64'h100;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_mid_wait_outputs", 64'(anyOut(1)), 64'h0);
      rst = 1'b0; iIReq[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (oIAck[1] || oDAck[1]) stray++;
      end
      check("reset_mid_wait_stray_acks", 64'(stray), 64'h0);
      runOne(1, rv);
    end

    for (int i = 0; i < 8; i++) runOne(0, tbl[i]);

    for (int k = 0; k < 3; k++) begin
      int  g = (k == 0) ? 0 : k + 1;
      vecT sv = '{1'b0, 1'b0, 64'h40, 64'h0, 8'h00, 2 + latOf(g), initWord(8), 1'b0, 1, 64'h40, 8'hFF, ""};
      sv.name = $sformatf("sweep_L%0d", latOf(g));
      runOne(g, sv);
    end

    // Both ports held continuously with a streak limit of 2.
    begin
      logic [5:0] order = 6'b0;
      int         nAck = 0;
      @(negedge clk);
      iIReq[0] = 1'b1; iIAddress[0] = 64'h100;
      iDReq[0] = 1'b1; iDWrite[0] = 1'b0; iDAddress[0] = 64'h48;
      for (int c = 0; c < 200 && nAck < 6; c++) begin
        @(negedge clk);
        if (oIAck[0] && oDAck[0]) check("contention_simultaneous_ack", 64'h1, 64'h0);
        if (oIAck[0] || oDAck[0]) begin
          order = {order[4:0], oDAck[0]};
          check($sformatf("contention_busyD[%0d]", nAck), 64'(oBusyD[0]), 64'(oDAck[0]));
          nAck++;
        end
      end
      iIReq[0] = 1'b0; iDReq[0] = 1'b0;
      check("contention_ack_count", 64'(nAck), 64'd6);
      check("contention_order_DDIDDI", 64'(order), 64'(6'b110110));
    end

    // Randomized traffic against a transaction-level model of instance 0.
    pulseReset();
    for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
    begin
      int          freeAt = 0, expAck = -1, expEn = -1, streakM = 0;
      logic        pend = 1'b0, expIsI = 1'b0, expFault = 1'b0;
      logic        eIA, eDA, eEn;
      logic [63:0] expData = 64'h0, w;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        eIA = pend && c == expAck && expIsI;
        eDA = pend && c == expAck && !expIsI;
        eEn = pend && c == expEn;
        check("rnd_ctl", 64'({oIAck[0], oIFault[0], oDAck[0], oMemEnable[0]}),
              64'({eIA, eIA && expFault, eDA, eEn}));
        if (eIA) check("rnd_idata", 64'(oIReadData[0]), expData);
        if (eDA && !iDWrite[0]) check("rnd_ddata", oDReadData[0], expData);
        if (pend && c == expAck) pend = 1'b0;
        if (eIA) iIReq[0] = 1'b0;
        if (eDA) iDReq[0] = 1'b0;
        if (!iIReq[0] && $urandom_range(0, 2) == 0) begin
          iIReq[0]     = 1'b1;
          iIAddress[0] = 64'($urandom_range(0, 127)) << 2;
          if ($urandom_range(0, 7) == 0) iIAddress[0] = iIAddress[0] + 64'($urandom_range(1, 3));
        end
        if (!iDReq[0] && $urandom_range(0, 1) == 0) begin
          iDReq[0]        = 1'b1;
          iDWrite[0]      = 1'($urandom_range(0, 1));
          iDAddress[0]    = 64'($urandom_range(0, 511));
          iDWriteData[0]  = {32'($urandom), 32'($urandom)};
          iDByteEnable[0] = 8'($urandom_range(0, 255));
        end
        if (!pend && c >= freeAt && (iIReq[0] || iDReq[0])) begin
          pend = 1'b1; expFault = 1'b0; expEn = c + 1;
          if (iDReq[0] && (!iIReq[0] || streakM < 2)) begin
            expIsI  = 1'b0;
            streakM = iIReq[0] ? ((streakM < 2) ? streakM + 1 : 2) : 0;
            w = refMem[iDAddress[0][8:3]];
            if (iDWrite[0]) begin
              for (int b = 0; b < 8; b++)
                if (iDByteEnable[0][b]) w[b*8 +: 8] = iDWriteData[0][b*8 +: 8];
              refMem[iDAddress[0][8:3]] = w;
              expData = 64'h0;
              expAck  = c + 2;
            end else begin
              expData = w;
              expAck  = c + 2 + latOf(0);
            end
          end else begin
            expIsI  = 1'b1;
            streakM = 0;
            w = refMem[iIAddress[0][8:3]];
            if (iIAddress[0][1:0] != 2'b00) begin
              expFault = 1'b1; expData = 64'h0; expAck = c + 1; expEn = -1;
            end else begin
              expData = iIAddress[0][2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
              expAck  = c + 2 + latOf(0);
            end
          end
          freeAt = expAck + 1;
        end
      end
      iIReq[0] = 1'b0; iDReq[0] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
